mpu_sequencer: RTL and testbench

//  Instruction fetch/issue controller for the MPU.
//  - Fetches 48-bit variable-length instructions from a 64-bit-wide byte-addressed instruction memory.
//  - Drives the window to mpu_decoder and advances ip by the decoder's isize.
//  - Hands each valid instruction to the execute unit over a valid/ready handshake.
//  - Applies jumps and halts returned by the execute unit.

---
 rtl/mpu_sequencer_if.sv | 33 +++
 rtl/mpu_sequencer.sv | 104 ++++++++++
 tb/tb_mpu_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mpu_sequencer_if.sv
// Sequencer bus: start control, instruction memory port, decoder window and execute handshake.
// The master modport is the sequencer side; slave is the surrounding environment.
interface mpu_sequencer_if #(
   parameter int IADDR_W = 12
);
   logic               start;
   logic [IADDR_W-1:0] start_ip;
   logic               m_re;
   logic [IADDR_W-4:0] m_addr;
   logic [63:0]        m_data;
   logic [47:0]        i;
   logic [15:0]        isize;
   logic               error;
   logic               exec_valid;
   logic               exec_ready;
   logic               exec_halt;
   logic               jmp;
   logic [IADDR_W-1:0] jmp_addr;
   logic [IADDR_W-1:0] ip;
   logic               busy;
   logic               done;
   logic               err;

   modport master (
      input  start, start_ip, m_data, isize, error, exec_ready, exec_halt, jmp, jmp_addr,
      output m_re, m_addr, i, exec_valid, ip, busy, done, err
   );

   modport slave (
      output start, start_ip, m_data, isize, error, exec_ready, exec_halt, jmp, jmp_addr,
      input  m_re, m_addr, i, exec_valid, ip, busy, done, err
   );
endinterface

// File: rtl/mpu_sequencer.sv
// MPU instruction fetch/issue controller: two-word fetch per instruction, byte-aligned
// 48-bit window to the decoder, valid/ready issue to execute, jump and halt handling.
module mpu_sequencer #(
   parameter int IADDR_W = 12
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   mpu_sequencer_if.master       bus
);
   typedef enum logic [2:0] {IDLE, F0, F1, F2, EXEC} state_t;

   state_t             r_state;
   logic [IADDR_W-1:0] r_ip;
   logic [IADDR_W-4:0] r_m_addr;
   logic               r_m_re;
   logic               r_busy;
   logic               r_done;
   logic               r_err;
   logic [63:0]        r_lo;
   logic [63:0]        r_hi;

   logic               w_illegal;
   logic               w_valid;
   logic               w_accept;
   logic [IADDR_W-1:0] w_next_ip;
   logic [5:0]         w_shift;

   // Two consecutive words cover any 6-byte instruction starting at any byte offset.
   assign w_shift    = {r_ip[2:0], 3'b000};
   assign bus.i      = 48'({r_hi, r_lo} >> w_shift);

   assign w_illegal  = bus.error || (bus.isize == 16'd0) || (bus.isize > 16'd6);
   assign w_valid    = (r_state == EXEC) && !w_illegal;
   assign w_accept   = w_valid && bus.exec_ready;
   assign w_next_ip  = bus.jmp ? bus.jmp_addr : r_ip + bus.isize[IADDR_W-1:0];

   assign bus.exec_valid = w_valid;
   assign bus.m_re       = r_m_re;
   assign bus.m_addr     = r_m_addr;
   assign bus.ip         = r_ip;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.err        = r_err;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state  <= IDLE;
         r_ip     <= '0;
         r_m_addr <= '0;
         r_m_re   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_lo     <= '0;
         r_hi     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: if (bus.start) begin
               r_ip     <= bus.start_ip;
               r_err    <= 1'b0;
               r_busy   <= 1'b1;
               r_m_re   <= 1'b1;
               r_m_addr <= bus.start_ip[IADDR_W-1:3];
               r_state  <= F0;
            end
            F0: begin
               // Second word of the window; wraps past the last word to word 0.
               r_m_addr <= r_ip[IADDR_W-1:3] + (IADDR_W-3)'(1);
               r_state  <= F1;
            end
            F1: begin
               r_lo    <= bus.m_data;
               r_m_re  <= 1'b0;
               r_state <= F2;
            end
            F2: begin
               r_hi    <= bus.m_data;
               r_state <= EXEC;
            end
            EXEC: begin
               if (w_illegal) begin
                  r_err   <= 1'b1;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else if (w_accept) begin
                  if (bus.exec_halt) begin
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= IDLE;
                  end else begin
                     r_ip     <= w_next_ip;
                     r_m_re   <= 1'b1;
                     r_m_addr <= w_next_ip[IADDR_W-1:3];
                     r_state  <= F0;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mpu_sequencer.sv
// Directed bench for mpu_sequencer: expected fetch addresses and issued instructions go into
// scoreboard queues; monitors pop and compare whenever the DUT reads memory or issues.
module tb_mpu_sequencer;
   localparam int IADDR_W = 12;

   logic clk;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   int   n;
   logic saw_valid;

   logic [63:0] mem [0:511];
   logic [8:0]  fq[$];
   logic [59:0] eq[$];

   mpu_sequencer_if #(.IADDR_W(IADDR_W)) bus();

   mpu_sequencer #(.IADDR_W(IADDR_W)) dut (
      .sys_clk (clk),
      .sys_rst (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: registered read, data valid the cycle after m_re.
   always @(posedge clk) if (bus.m_re) bus.m_data <= mem[bus.m_addr];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Fetch monitor
   always @(negedge clk) begin
      if (!rst && bus.m_re) begin
         if (fq.size() == 0) chk("fetch_unexpected", {55'd0, bus.m_addr}, 64'h1_0000);
         else chk("fetch_addr", {55'd0, bus.m_addr}, {55'd0, fq.pop_front()});
      end
   end

   // Issue monitor
   always @(negedge clk) begin
      if (!rst && bus.exec_valid && bus.exec_ready) begin
         if (eq.size() == 0) chk("issue_unexpected", {4'd0, bus.i, bus.ip}, 64'hF000_0000_0000_0000);
         else chk("issue_i_ip", {4'd0, bus.i, bus.ip}, {4'd0, eq.pop_front()});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic pulse_start(input logic [IADDR_W-1:0] a);
      bus.start    = 1'b1;
      bus.start_ip = a;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   // Edges after the current cycle until exec_valid is seen (bounded).
   task automatic wait_valid(output int cnt);
      cnt = 0;
      @(negedge clk);
      while (!bus.exec_valid && cnt < 50) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
      end
   endtask

   task automatic check_done_after_accept(input string nm);
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_done"}, {63'd0, bus.done}, 64'd1);
      chk({nm, "_busy"}, {63'd0, bus.busy}, 64'd0);
   endtask

   initial begin
      for (int k = 0; k < 512; k++) mem[k] = 64'd0;
      rst = 1'b1;
      bus.start = 1'b0; bus.start_ip = '0; bus.isize = 16'd2; bus.error = 1'b0;
      bus.exec_ready = 1'b1; bus.exec_halt = 1'b0; bus.jmp = 1'b0; bus.jmp_addr = '0;
      bus.m_data = 64'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_outs", {bus.m_re, bus.exec_valid, bus.busy, bus.done, bus.err}, 64'd0);
      chk("rst_ip_i", {4'd0, bus.i, bus.ip}, 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // 1: aligned 2-byte op, then halt on the next one at ip=2
      mem[0] = 64'h0000_0000_0000_0105;
      fq.push_back(9'h000); fq.push_back(9'h001); fq.push_back(9'h000); fq.push_back(9'h001);
      eq.push_back({48'h0000_0000_0105, 12'h000});
      eq.push_back({48'h0000_0000_0000, 12'h002});
      pulse_start(12'h000);
      wait_valid(n);
      chk("t1_latency", n, 3);
      @(posedge clk);
      #1 bus.exec_halt = 1'b1;
      wait_valid(n);
      chk("t1_throughput", n, 3);
      check_done_after_accept("t1");
      @(negedge clk);
      chk("t1_done_pulse", {63'd0, bus.done}, 64'd0);

      // 2: straddling window at ip=6
      mem[0] = 64'hBBAA_0000_0000_0105;
      mem[1] = 64'h0000_0000_FFEE_DDCC;
      fq.push_back(9'h000); fq.push_back(9'h001);
      eq.push_back({48'hFFEE_DDCC_BBAA, 12'h006});
      pulse_start(12'h006);
      wait_valid(n);
      chk("t2_i", {16'd0, bus.i}, 64'hFFEE_DDCC_BBAA);
      check_done_after_accept("t2");

      // 3: stall 5 cycles, then accept with jump to 0x100
      #1 bus.exec_halt = 1'b0; bus.exec_ready = 1'b0; bus.isize = 16'd3;
      mem[2]    = 64'h0123_4567_89AB_CDEF;
      mem[3]    = 64'h0000_0000_0000_0000;
      mem[9'h20] = 64'h0000_AAAA_BBBB_CCCC;
      fq.push_back(9'h002); fq.push_back(9'h003);
      eq.push_back({48'h4567_89AB_CDEF, 12'h010});
      pulse_start(12'h010);
      wait_valid(n);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk("t3_hold", {bus.exec_valid, bus.m_re, 14'd0, bus.i}, {2'b10, 14'd0, 48'h4567_89AB_CDEF});
      end
      fq.push_back(9'h020); fq.push_back(9'h021);
      eq.push_back({48'hAAAA_BBBB_CCCC, 12'h100});
      @(posedge clk);
      #1 bus.jmp = 1'b1; bus.jmp_addr = 12'h100; bus.exec_ready = 1'b1;
      @(posedge clk);
      #1 bus.jmp = 1'b0; bus.exec_halt = 1'b1;
      wait_valid(n);
      chk("t3_jump_latency", n, 3);
      check_done_after_accept("t3");

      // 4: decoder error, then a fresh start clears err
      #1 bus.error = 1'b1;
      fq.push_back(9'h000); fq.push_back(9'h001);
      pulse_start(12'h000);
      n = 0; saw_valid = 1'b0;
      @(negedge clk);
      while (!bus.done && n < 50) begin
         if (bus.exec_valid) saw_valid = 1'b1;
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk("t4_done_edges", n, 4);
      chk("t4_no_valid", {63'd0, saw_valid}, 64'd0);
      chk("t4_err_busy", {bus.err, bus.busy}, 64'd2);
      @(posedge clk);
      #1 bus.error = 1'b0;
      fq.push_back(9'h000); fq.push_back(9'h001);
      eq.push_back({48'h0000_0000_0105, 12'h000});
      pulse_start(12'h000);
      @(negedge clk);
      chk("t4_err_cleared", {bus.err, bus.busy}, 64'd1);
      wait_valid(n);
      check_done_after_accept("t4");

      // 5: wrap from word 0x1FF to word 0 and ip from 0xFFE to 0x002
      #1 bus.exec_halt = 1'b0; bus.isize = 16'd4;
      mem[511] = 64'h2222_1111_0000_0000;
      fq.push_back(9'h1FF); fq.push_back(9'h000); fq.push_back(9'h000); fq.push_back(9'h001);
      eq.push_back({48'h0000_0105_2222, 12'hFFE});
      eq.push_back({48'hBBAA_0000_0000, 12'h002});
      pulse_start(12'hFFE);
      wait_valid(n);
      @(posedge clk);
      #1 bus.exec_halt = 1'b1;
      wait_valid(n);
      chk("t5_wrap_ip", {52'd0, bus.ip}, 64'h002);
      check_done_after_accept("t5");

      // 6: async reset in F1 with start held, then a fresh run
      fq.push_back(9'h002);
      #1 bus.start = 1'b1; bus.start_ip = 12'h010; bus.isize = 16'd3;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("t6_rst_outs", {bus.m_re, bus.exec_valid, bus.busy, bus.done, bus.err}, 64'd0);
      chk("t6_rst_regs", {bus.i, bus.ip}, 64'd0);
      chk("t6_rst_maddr", {55'd0, bus.m_addr}, 64'd0);
      @(posedge clk);
      @(posedge clk);
      fq.push_back(9'h002); fq.push_back(9'h003);
      eq.push_back({48'h4567_89AB_CDEF, 12'h010});
      #1 rst = 1'b0;
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_valid(n);
      chk("t6_restart_latency", n, 3);
      check_done_after_accept("t6");

      repeat (2) @(posedge clk);
      chk("fetch_queue_empty", fq.size(), 0);
      chk("issue_queue_empty", eq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
